// File: rtl/byte_data_memory_if.sv
// Request/response bus for byte_data_memory: one request channel, one held response.
// The slave modport is the memory side; the master modport is the requester side.
interface byte_data_memory_if #(
   parameter int memory_addr_size = 8
);
   logic                        req_valid;
   logic                        req_ready;
   logic                        req_write;
   logic [1:0]                  req_size;
   logic                        req_unsigned;
   logic [memory_addr_size-1:0] req_addr;
   logic [31:0]                 req_wdata;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [31:0]                 rsp_data;
   logic                        rsp_error;

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_error
   );

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_error
   );
endinterface

// File: rtl/byte_data_memory.sv
// Big-endian byte-addressed data memory with a one-cycle request/response handshake.
// Optional alignment checking is enabled by defining DMEM_MISALIGN_CHECK_EN.
module byte_data_memory #(
   parameter int memory_size      = 256,
   parameter int memory_addr_size = 8
) (
   input  logic              clk,
   input  logic              rst,
   byte_data_memory_if.slave bus
);
   localparam int BANK_DEPTH = memory_size / 4;

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic        w_req_ready;
   logic        w_rsp_valid;
   logic        w_accept;
   logic        w_misalign;
   logic        w_do_write;
   logic [1:0]  w_last_lane;
   logic [7:0]  w_rd_byte [4];

   logic [1:0]  r_base;
   logic [1:0]  r_size;
   logic        r_unsigned;
   logic        r_is_load;
   logic        r_err;

   logic [7:0]  w_b [4];
   logic [31:0] w_load_val;
   logic [31:0] w_rsp_data;

   assign w_req_ready = (r_state == IDLE) || bus.rsp_ready;
   assign w_accept    = bus.req_valid && w_req_ready;

`ifdef DMEM_MISALIGN_CHECK_EN
   assign w_misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                       (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_do_write = w_accept && bus.req_write && !w_misalign && !rst;

   // Index of the last byte lane touched, counted from req_addr.
   always_comb begin
      w_last_lane = 2'd3;
      case (bus.req_size)
         2'b00:   w_last_lane = 2'd0;
         2'b01:   w_last_lane = 2'd1;
         default: w_last_lane = 2'd3;
      endcase
   end

   // Bank gi holds every byte whose address is gi mod 4, so any access of up to
   // four consecutive (wrapping) bytes touches each bank at most once.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_bank
         localparam logic [1:0] BANK = 2'(gi);
         logic [1:0]                  w_lane;
         logic [memory_addr_size-1:0] w_byte_addr;
         logic [1:0]                  w_src;
         logic [7:0]                  w_wr_byte;
         logic                        w_we;
         logic [7:0]                  r_mem [0:BANK_DEPTH-1];
         logic [7:0]                  r_rd;

         assign w_lane      = BANK - bus.req_addr[1:0];
         assign w_byte_addr = bus.req_addr + memory_addr_size'(w_lane);
         assign w_src       = w_last_lane - w_lane;
         assign w_wr_byte   = bus.req_wdata[8*w_src +: 8];
         assign w_we        = w_do_write && (w_lane <= w_last_lane);

         always_ff @(posedge clk) begin
            if (w_we) begin
               r_mem[w_byte_addr[memory_addr_size-1:2]] <= w_wr_byte;
            end
            if (w_accept) begin
               r_rd <= r_mem[w_byte_addr[memory_addr_size-1:2]];
            end
         end

         assign w_rd_byte[gi] = r_rd;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_base     <= 2'd0;
         r_size     <= 2'd0;
         r_unsigned <= 1'b0;
         r_is_load  <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_base     <= bus.req_addr[1:0];
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
            r_is_load  <= !bus.req_write;
            r_err      <= w_misalign;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_rsp_valid  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_next = RESP;
            end
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (w_accept) begin
               w_state_next = RESP;
            end else if (bus.rsp_ready) begin
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Reorder the registered bank bytes back into address order (w_b[0] = byte at addr).
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         w_b[j] = w_rd_byte[r_base + 2'(j)];
      end
   end

   always_comb begin
      w_load_val = 32'd0;
      case (r_size)
         2'b00:   w_load_val = r_unsigned ? {24'd0, w_b[0]} : {{24{w_b[0][7]}}, w_b[0]};
         2'b01:   w_load_val = r_unsigned ? {16'd0, w_b[0], w_b[1]}
                                          : {{16{w_b[0][7]}}, w_b[0], w_b[1]};
         default: w_load_val = {w_b[0], w_b[1], w_b[2], w_b[3]};
      endcase
   end

   // Gating by state lets the async reset clear the output without resetting the RAM read registers.
   always_comb begin
      w_rsp_data = 32'd0;
      if ((r_state == RESP) && r_is_load && !r_err) begin
         w_rsp_data = w_load_val;
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = w_rsp_valid;
   assign bus.rsp_data  = w_rsp_data;
   assign bus.rsp_error = (r_state == RESP) && r_err;
endmodule

// File: tb/tb_byte_data_memory.sv
// Directed testbench for byte_data_memory; expected values are hand-computed constants.
module tb_byte_data_memory;
   logic clk;
   logic rst;
   int   checks_cnt;
   int   fail_cnt;

   byte_data_memory_if #(.memory_addr_size(8)) bus ();

   byte_data_memory #(
      .memory_size(256),
      .memory_addr_size(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

`ifdef DMEM_MISALIGN_CHECK_EN
   localparam logic        EXP_WRAP_ERR = 1'b1;
   localparam logic [31:0] EXP_FE = 32'h01;
   localparam logic [31:0] EXP_FF = 32'h02;
   localparam logic [31:0] EXP_00 = 32'h03;
   localparam logic [31:0] EXP_01 = 32'h04;
`else
   localparam logic        EXP_WRAP_ERR = 1'b0;
   localparam logic [31:0] EXP_FE = 32'hA1;
   localparam logic [31:0] EXP_FF = 32'hB2;
   localparam logic [31:0] EXP_00 = 32'hC3;
   localparam logic [31:0] EXP_01 = 32'hD4;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("ok   %s got=%h", tag, got);
      end
   endtask

   // Called at a negedge; returns at the negedge following acceptance with the response.
   task automatic xfer(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                       input logic [31:0] d, output logic [31:0] data, output logic err);
      int wait_cnt;
      wait_cnt          = 0;
      bus.req_valid     = 1'b1;
      bus.req_write     = w;
      bus.req_size      = sz;
      bus.req_unsigned  = u;
      bus.req_addr      = a;
      bus.req_wdata     = d;
      while (!bus.req_ready && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (wait_cnt >= 20) check_eq("req_ready_wait", 32'(bus.req_ready), 32'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
      data = bus.rsp_data;
      err  = bus.rsp_error;
   endtask

   task automatic store(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d,
                        input logic exp_err);
      logic [31:0] data;
      logic        err;
      xfer(1'b1, sz, 1'b0, a, d, data, err);
      check_eq($sformatf("st%0d@%h data", sz, a), data, 32'd0);
      check_eq($sformatf("st%0d@%h err", sz, a), 32'(err), 32'(exp_err));
   endtask

   task automatic load(input logic [1:0] sz, input logic u, input logic [7:0] a,
                       input logic [31:0] exp);
      logic [31:0] data;
      logic        err;
      xfer(1'b0, sz, u, a, 32'd0, data, err);
      check_eq($sformatf("ld%0d%s@%h", sz, u ? "u" : "s", a), data, exp);
      check_eq($sformatf("ld%0d@%h err", sz, a), 32'(err), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d", checks_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] b2b_exp [4];
      checks_cnt       = 0;
      fail_cnt         = 0;
      rst              = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_write    = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 8'h00;
      bus.req_wdata    = 32'd0;
      bus.rsp_ready    = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("reset req_ready", 32'(bus.req_ready), 32'd1);
      check_eq("reset rsp_data", bus.rsp_data, 32'd0);
      check_eq("reset rsp_error", 32'(bus.rsp_error), 32'd0);

      // Word store, then byte/half/word loads of it.
      store(2'b10, 8'h10, 32'h11223344, 1'b0);
      load(2'b00, 1'b1, 8'h10, 32'h00000011);
      load(2'b00, 1'b1, 8'h13, 32'h00000044);
      load(2'b01, 1'b0, 8'h12, 32'h00003344);
      load(2'b11, 1'b1, 8'h10, 32'h11223344);

      // Byte store inside a known word; sign/zero extension; neighbours unchanged.
      store(2'b10, 8'h20, 32'hAABBCCDD, 1'b0);
      store(2'b00, 8'h20, 32'h12345680, 1'b0);
      load(2'b00, 1'b0, 8'h20, 32'hFFFFFF80);
      load(2'b00, 1'b1, 8'h20, 32'h00000080);
      load(2'b10, 1'b0, 8'h20, 32'h80BBCCDD);

      // Half store and extension.
      store(2'b01, 8'h30, 32'hDEADBEEF, 1'b0);
      load(2'b01, 1'b0, 8'h30, 32'hFFFFBEEF);
      load(2'b01, 1'b1, 8'h30, 32'h0000BEEF);
      load(2'b00, 1'b1, 8'h31, 32'h000000EF);

      // Backpressure: response held three cycles, next request waits.
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
      bus.req_unsigned = 1'b0; bus.req_addr = 8'h10;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      bus.req_size = 2'b00; bus.req_unsigned = 1'b1; bus.req_addr = 8'h13;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq($sformatf("stall%0d rsp_valid", i), 32'(bus.rsp_valid), 32'd1);
         check_eq($sformatf("stall%0d req_ready", i), 32'(bus.req_ready), 32'd0);
         check_eq($sformatf("stall%0d rsp_data", i), bus.rsp_data, 32'h11223344);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq("after stall rsp_data", bus.rsp_data, 32'h00000044);

      // Back-to-back: one response per cycle.
      b2b_exp[0] = 32'h11; b2b_exp[1] = 32'h22; b2b_exp[2] = 32'h33; b2b_exp[3] = 32'h44;
      for (int k = 0; k < 4; k++) begin
         check_eq($sformatf("b2b%0d req_ready", k), 32'(bus.req_ready), 32'd1);
         bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b00;
         bus.req_unsigned = 1'b1; bus.req_addr = 8'h10 + 8'(k);
         @(posedge clk);
         @(negedge clk);
         check_eq($sformatf("b2b%0d rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
         check_eq($sformatf("b2b%0d rsp_data", k), bus.rsp_data, b2b_exp[k]);
      end
      bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq("b2b drain rsp_valid", 32'(bus.rsp_valid), 32'd0);

      // Misaligned word store that wraps past the top of memory.
      store(2'b00, 8'hFE, 32'h01, 1'b0);
      store(2'b00, 8'hFF, 32'h02, 1'b0);
      store(2'b00, 8'h00, 32'h03, 1'b0);
      store(2'b00, 8'h01, 32'h04, 1'b0);
      store(2'b10, 8'hFE, 32'hA1B2C3D4, EXP_WRAP_ERR);
      load(2'b00, 1'b1, 8'hFE, EXP_FE);
      load(2'b00, 1'b1, 8'hFF, EXP_FF);
      load(2'b00, 1'b1, 8'h00, EXP_00);
      load(2'b00, 1'b1, 8'h01, EXP_01);

      // Reset while a response is held; a store presented during reset is dropped.
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_addr = 8'h10;
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check_eq("pre-rst rsp_valid", 32'(bus.rsp_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_eq("rst req_ready", 32'(bus.req_ready), 32'd1);
      check_eq("rst rsp_data", bus.rsp_data, 32'd0);
      check_eq("rst rsp_error", 32'(bus.rsp_error), 32'd0);
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'b00;
      bus.req_addr = 8'h10; bus.req_wdata = 32'hFF;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check_eq("post-rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
      load(2'b00, 1'b1, 8'h10, 32'h00000011);
      load(2'b10, 1'b0, 8'h20, 32'h80BBCCDD);

      $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
      $finish;
   end
endmodule
